// File: rtl/cpu_fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, instruction length codes
// and the opcode field masks used to classify 8008 instructions.
package cpu_fetch_pkg;

  localparam int ADDR_W = 14;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B2 = 2'd1,
    FETCH_B3 = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Group field op[7:6] and low field op[2:0] select the immediate formats
  localparam logic [7:0] OP_GRP_MASK  = 8'hC0;
  localparam logic [7:0] OP_GRP_IMM   = 8'h00;
  localparam logic [7:0] OP_GRP_JMP   = 8'h40;
  localparam logic [7:0] OP_LOW3_MASK = 8'h07;
  localparam logic [7:0] OP_LOW3_MVI  = 8'h06;
  localparam logic [7:0] OP_LOW3_ALUI = 8'h04;
  localparam logic [7:0] OP_BIT0_MASK = 8'h01;

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch unit bus bundle: byte-wide program memory read handshake and the
// instruction valid/ready handshake towards decode.
interface cpu_fetch_if;
  import cpu_fetch_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [7:0]        mem_data;

  logic              f_valid;
  logic              d_ready;
  logic [7:0]        f_opcode;
  logic [7:0]        f_data1;
  logic [7:0]        f_data2;
  logic [1:0]        f_len;
  logic [ADDR_W-1:0] f_pc;

  modport master (
    output mem_addr, mem_rd,
    input  mem_ack, mem_data,
    output f_valid, f_opcode, f_data1, f_data2, f_len, f_pc,
    input  d_ready
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_ack, mem_data,
    input  f_valid, f_opcode, f_data1, f_data2, f_len, f_pc,
    output d_ready
  );

endinterface

// File: rtl/cpu_fetch_ilen.sv
// Combinational 8008 opcode-to-length decoder (1, 2 or 3 bytes); shared with decode.
module cpu_ilen
  import cpu_fetch_pkg::*;
(
  input  logic [7:0] i_op,
  output logic [1:0] o_len
);

  logic [7:0] w_grp;
  logic [7:0] w_low3;
  logic [7:0] w_bit0;

  assign w_grp  = i_op & OP_GRP_MASK;
  assign w_low3 = i_op & OP_LOW3_MASK;
  assign w_bit0 = i_op & OP_BIT0_MASK;

  always_comb begin
    o_len = LEN_1;
    if ((w_grp == OP_GRP_IMM) && ((w_low3 == OP_LOW3_MVI) || (w_low3 == OP_LOW3_ALUI))) begin
      o_len = LEN_2;
    end else if ((w_grp == OP_GRP_JMP) && (w_bit0 == 8'h00)) begin
      o_len = LEN_3;
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: reads 1-3 bytes per instruction over the memory handshake and
// holds the assembled instruction until decode accepts it; flush restarts at i_pc.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 14'h0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_pc,
  cpu_fetch_if.master       bus
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [7:0]        r_op;
  logic [7:0]        r_d1;
  logic [7:0]        r_d2;
  logic [1:0]        r_len;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        w_len;

  cpu_ilen u_ilen (
    .i_op  (bus.mem_data),
    .o_len (w_len)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FETCH_OP;
      r_addr  <= RESET_PC;
      r_valid <= 1'b0;
      r_op    <= 8'h00;
      r_d1    <= 8'h00;
      r_d2    <= 8'h00;
      r_len   <= LEN_1;
      r_pc    <= RESET_PC;
    end else if (i_flush) begin
      // A same-cycle ack or decode accept is dropped with the old stream
      r_state <= FETCH_OP;
      r_addr  <= i_pc;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (bus.mem_ack) begin
            r_op   <= bus.mem_data;
            r_pc   <= r_addr;
            r_d1   <= 8'h00;
            r_d2   <= 8'h00;
            r_len  <= w_len;
            r_addr <= r_addr + 14'd1;
            if (w_len != LEN_1) begin
              r_state <= FETCH_B2;
            end else begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        FETCH_B2: begin
          if (bus.mem_ack) begin
            r_d1   <= bus.mem_data;
            r_addr <= r_addr + 14'd1;
            if (r_len == LEN_3) begin
              r_state <= FETCH_B3;
            end else begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        FETCH_B3: begin
          if (bus.mem_ack) begin
            r_d2    <= bus.mem_data;
            r_addr  <= r_addr + 14'd1;
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.d_ready) begin
            r_valid <= 1'b0;
            r_state <= FETCH_OP;
          end
        end
        default: begin
          r_state <= FETCH_OP;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd   = (r_state != HOLD) && !i_rst;
  assign bus.mem_addr = r_addr;
  assign bus.f_valid  = r_valid;
  assign bus.f_opcode = r_op;
  assign bus.f_data1  = r_d1;
  assign bus.f_data2  = r_d2;
  assign bus.f_len    = r_len;
  assign bus.f_pc     = r_pc;

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction fetch unit for the MCS8 pipelined core.
- Takes the program counter and branch redirects from the PC/stack logic, reads instruction bytes over a byte-wide memory read handshake, and determines 8008 instruction length (1, 2 or 3 bytes).
- Presents one complete instruction (opcode plus immediates) to the decode stage with a valid/ready handshake.
- Sits between program memory and the decode stage; its F_OPCODE_O feeds the decode/PC logic's opcode input.

Parameters:
RESET_PC, 14'h0000, fetch address loaded on reset.

Ports:
CLK_I  in  1  system clock, rising edge.
RST_I  in  1  reset, synchronous, active-high.
FLUSH_I  in  1  redirect: discard the current fetch/instruction and restart at PC_I.
PC_I  in  14  redirect target; sampled only when FLUSH_I=1.
MEM_ADDR_O  out  14  byte address of the current read.
MEM_RD_O  out  1  read request; held with a stable address until acknowledged.
MEM_ACK_I  in  1  read done; MEM_DATA_I is valid in the same cycle; ignored while MEM_RD_O=0.
MEM_DATA_I  in  8  read data.
F_VALID_O  out  1  instruction buffer holds a complete instruction.
D_READY_I  in  1  decode accepts the instruction this cycle.
F_OPCODE_O  out  8  first byte.
F_DATA1_O  out  8  second byte (0 if length < 2).
F_DATA2_O  out  8  third byte (0 if length < 3).
F_LEN_O  out  2  instruction length, 1..3.
F_PC_O  out  14  address of the first byte.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - RST_I dominates every other input.
- Reset values:
  - F_VALID_O=0; F_OPCODE_O, F_DATA1_O and F_DATA2_O = 0; F_LEN_O=1.
  - F_PC_O=RESET_PC; fetch address rAddr=RESET_PC; state=FETCH_OP.
  - MEM_RD_O=0 while RST_I=1.
- Output decode:
  - MEM_RD_O=1 exactly when state is FETCH_OP, FETCH_B2 or FETCH_B3 and RST_I=0.
  - MEM_ADDR_O=rAddr.
- State FETCH_OP, on ACK:
  - Latch opcode; F_PC_O=rAddr; clear the data bytes; rAddr+1.
  - Go to FETCH_B2 if length>1, else HOLD.
- State FETCH_B2, on ACK:
  - Latch F_DATA1_O; rAddr+1.
  - Go to FETCH_B3 if length=3, else HOLD.
- State FETCH_B3, on ACK:
  - Latch F_DATA2_O; rAddr+1; go to HOLD.
- Any fetch state without ACK: hold state and address.
- State HOLD:
  - F_VALID_O=1.
  - When D_READY_I=1: F_VALID_O=0 next cycle and go to FETCH_OP at the already-advanced rAddr.
- Length decode on the opcode byte op:
  - op[7:6]=00 and op[2:0] is 110 or 100: length 2 (MVI, ALU immediate).
  - op[7:6]=01 and op[0]=0: length 3 (JMP, JFc/JTc, CAL, CFc/CTc).
  - All other opcodes: length 1 (including HLT 00/01/FF, RST, RET, IN/OUT, register ops).
- Latency:
  - Acknowledge of the last byte in cycle N: F_VALID_O=1 in cycle N+1.
  - With zero-wait memory (ACK in the same cycle as RD): 1-byte instruction every 2 cycles; 3-byte every 4 cycles.
- Address wrap: rAddr 14'h3FFF + 1 = 14'h0000, including in the middle of an instruction.
- Flush, in any state:
  - Next cycle: state=FETCH_OP, rAddr=PC_I, F_VALID_O=0.
  - An ACK or D_READY_I in the same cycle is discarded and has no effect on outputs.
  - The memory side must tolerate MEM_RD_O dropping without an acknowledge.
- Simultaneous FLUSH_I and RST_I: reset wins, rAddr=RESET_PC.
- HALT handling is not performed here; halting is done by not asserting D_READY_I.

Decomposition:
- Shared package/include (cpu_defs), holding:
  - State encodings: FETCH_OP=0, FETCH_B2=1, FETCH_B3=2, HOLD=3.
  - Length codes.
  - Opcode field masks, also used by the decode logic.
- Sub-module cpu_ilen: combinational opcode-to-length decoder, reused by decode.

Test Plan:
1. Reset, zero-wait memory with mem[0]=0xC1 (1-byte) -> MEM_ADDR_O=0 after reset release; F_VALID_O=1 with OPCODE=C1, LEN=1, F_PC_O=0 two cycles later; next fetch at address 1.
2. Memory holds 0x44,0x34,0x12 at 0x10 (JMP 0x1234), ACK delayed 2 cycles per byte -> LEN=3, DATA1=0x34, DATA2=0x12, F_PC_O=0x10; RD stays high with a stable address during waits.
3. mem[0x3FFF]=0x06 (MVI), mem[0]=0x55 -> the second byte is read from 0x0000; DATA1=0x55; next fetch at 0x0001.
4. Hold D_READY_I=0 for 5 cycles while F_VALID_O=1 -> outputs stable, MEM_RD_O=0; ready for 1 cycle -> F_VALID_O drops and the next fetch starts.
5. FLUSH_I with PC_I=0x0200 during FETCH_B2, together with ACK -> byte discarded; the next cycle reads 0x0200 as an opcode; F_VALID_O=0.
6. RST_I asserted mid-fetch of a 3-byte instruction -> next cycle F_VALID_O=0 and MEM_RD_O=0; after release, fetch restarts at RESET_PC.
